line_scan_ai: RTL and testbench
===============================

# line_scan_ai

Sequential, parametrised move generator for an N×N tic-tac-toe board. It captures a board snapshot on a start pulse and walks every line over successive cycles, in strict priority order: complete own line, block opponent line, take centre, then first free cell. It returns one move index with a done pulse. It replaces the single-shot 3×3 combinational AI and drives the board controller's move/submit path.

## Interface
- N, default 3: board side; 3..8 supported; cells = N*N, lines = 2N+2.
- AI_IS_O, default 1: 1 means the AI plays O (cell code 2'b10), opponent X (2'b01); 0 swaps them.
- IDX_W, default $clog2(N*N): width of move index.

Ports:
- Clock: clk, input, 1. One clock domain.
- Reset: reset, input, 1. Asynchronous, active-high.
- start: input, 1. Request a move; sampled only in IDLE.
- mode: input, 2. Strategy level, latched with start: 0 = fill only; 1 = win + fill; 2 = win + block + fill; 3 = win + block + centre + fill.
- board_state: input, 2*N*N. Cell i occupies bits [2i+1:2i], with i = row*N + col. Codes: 00 blank, 01 X, 10 O, 11 reserved (treated as occupied, neither player).
- busy: output, 1. High in every state except IDLE.
- done: output, 1. One-cycle pulse when a result is available.
- move_idx: output, IDX_W. Chosen cell, valid while done = 1.
- no_move: output, 1. Valid with done; 1 means the board has no blank cell and move_idx = 0.

## Operation
- States: IDLE, SCAN_WIN, SCAN_BLOCK, CENTER, FILL, DONE.
- IDLE:
  - On start = 1: latch board_state into board_q and mode into mode_q.
  - Clear line counter and cell counter.
  - Go to SCAN_WIN if mode ≥ 1, else FILL.
- Line order, index 0..2N+1: rows 0..N-1, then columns 0..N-1, then main diagonal (cells k*(N+1)), then anti-diagonal (cells (k+1)*(N-1)), for k = 0..N-1.
- Per-line evaluation (combinational, one line per cycle): count AI cells, opponent cells and blanks; record the lowest-index blank cell in the line.
- SCAN_WIN:
  - Hit when ai_cnt = N-1 and blank_cnt = 1: move_q ← that blank, go to DONE.
  - Otherwise, at the last line go to SCAN_BLOCK if mode ≥ 2, else FILL; counter cleared.
- SCAN_BLOCK: same as SCAN_WIN with opp_cnt = N-1. At the last line go to CENTER if mode = 3, else FILL.
- CENTER, one cycle:
  - If N is odd and cell (N*N-1)/2 is blank, move_q ← centre and go to DONE.
  - Otherwise go to FILL. For even N, always go to FILL.
- FILL:
  - Test cell cnt, one cell per cycle in ascending index order. The first blank sets move_q and goes to DONE.
  - If cell N*N-1 is not blank, set no_move_q = 1, move_q = 0, go to DONE.
- DONE, one cycle: done = 1, then go to IDLE.
- The first hit wins. Earlier lines in scan order take precedence over later ones; a win always takes precedence over a block.
- board_state and mode changes after the start cycle are ignored until the next accepted start.
- start asserted while busy is ignored; it is not queued.

## Timing
- Reset, asynchronous: state = IDLE, busy = 0, done = 0, move_idx = 0, no_move = 0, all counters 0.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Counting edges from the edge that samples start, done is high for the cycle following:
  - win hit on line L: edge 2 + L;
  - block hit on line L: edge 2 + (2N+2) + L;
  - centre: edge 2 + 2(2N+2);
  - fill hit at cell c: edge 2 + (scan cycles of earlier phases) + c.
- Worst case, N = 3, mode 3, with no hit before FILL and no blank cell: 1 + 8 + 8 + 1 + 9 + 1 = 28 cycles from start to the done cycle.
- busy rises on the edge after start is sampled and falls on the edge ending DONE. A new start is accepted on the first IDLE cycle after DONE.
- move_idx and no_move hold their values after done until the next accepted start; the consumer should sample them only with done.
- Reset asserted mid-scan aborts immediately, with no done pulse. Operation resumes with a fresh start after reset deasserts.

## Test plan
- N=3, mode 3, empty board, start at edge 0: done in cycle 18 with move_idx = 4, no_move = 0. busy is high in cycles 1–18.
- N=3, mode 3, O at cells 0 and 1, X at 3 and 4: win found on line 0. done in cycle 2 with move_idx = 2, even though a block at 5 is also available.
- N=3, mode 2, X at cells 0 and 4, O at 8, rest blank: no win; block on main diagonal? No (8 is O). The bench still checks the SCAN_BLOCK scan, then FILL: move_idx = 1 (first blank).
- N=4, AI_IS_O = 1, mode 3, X at cells 0, 5 and 10, O at 1 and 2:
  - Block hit on line 8 (main diagonal) gives move_idx = 15.
  - done in cycle 2 + 10 + 8 = 20.
- N=3, mode 0, all cells occupied (mix of X/O and one 11 code): no_move = 1, move_idx = 0. done in cycle 10.
- Reset and ignored start:
  - Assert reset in cycle 5 of a mode-3 scan: all outputs are 0 the same cycle, and no done pulse follows.
  - A start pulse while busy: the ongoing result is unchanged, and exactly one done pulse is produced.

Source files
------------

// File: rtl/line_scan_ai_if.sv
// line_scan_ai_if: request/result bundle between a move consumer and the
// line_scan_ai move generator.
//   start       : request a move (master -> slave)
//   mode        : strategy level, latched with start (master -> slave)
//   board_state : 2 bits per cell, cell i at [2i+1:2i] (master -> slave)
//   busy        : generator is working (slave -> master)
//   done        : one-cycle result strobe (slave -> master)
//   move_idx    : chosen cell, valid with done (slave -> master)
//   no_move     : board full, valid with done (slave -> master)
interface line_scan_ai_if #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N*N)
);
  logic               start;
  logic [1:0]         mode;
  logic [2*N*N-1:0]   board_state;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   move_idx;
  logic               no_move;

  modport master (
    output start, mode, board_state,
    input  busy, done, move_idx, no_move
  );

  modport slave (
    input  start, mode, board_state,
    output busy, done, move_idx, no_move
  );
endinterface

// File: rtl/line_scan_ai.sv
// line_scan_ai: sequential move generator for an N x N tic-tac-toe board.
// Snapshots the board on start, then scans one line per cycle for a win,
// then for a block, then tries the centre, then takes the first free cell.
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : line_scan_ai_if slave modport (start/mode/board_state in,
//           busy/done/move_idx/no_move out; all outputs registered or
//           decoded from the state register)
module line_scan_ai #(
  parameter int N       = 3,
  parameter bit AI_IS_O = 1'b1,
  parameter int IDX_W   = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          reset,
  line_scan_ai_if.slave bus
);

  localparam int unsigned NU       = N;
  localparam int unsigned CELLS    = NU*NU;
  localparam int unsigned LINES    = 2*NU + 2;
  localparam int          LINE_W   = $clog2(LINES);
  localparam int unsigned CENTRE_I = (CELLS - 1) / 2;
  localparam bit          ODD_N    = (N % 2) == 1;

  localparam logic [1:0]        AI_CODE   = AI_IS_O ? 2'b10 : 2'b01;
  localparam logic [1:0]        OPP_CODE  = AI_IS_O ? 2'b01 : 2'b10;
  localparam logic [3:0]        CNT_HIT   = 4'(N - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
  localparam logic [IDX_W-1:0]  LAST_CELL = IDX_W'(CELLS - 1);
  localparam logic [IDX_W-1:0]  CENTRE    = IDX_W'(CENTRE_I);

  typedef enum logic [2:0] {
    IDLE, SCAN_WIN, SCAN_BLOCK, CENTER, FILL, DONE
  } state_e;

  state_e               state_q, state_d;
  logic [2*CELLS-1:0]   board_q, board_d;
  logic [1:0]           mode_q, mode_d;
  logic                 pend_q, pend_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic [IDX_W-1:0]     cell_q, cell_d;
  logic [IDX_W-1:0]     move_q, move_d;
  logic                 no_move_q, no_move_d;

  // Evaluation of the line selected by line_q.
  logic [3:0]           ai_cnt, opp_cnt, blank_cnt;
  logic [IDX_W-1:0]     first_blank;
  logic [1:0]           fill_code;

  always_comb begin
    int unsigned ln;
    int unsigned ci;
    logic [1:0]  code;
    ai_cnt      = '0;
    opp_cnt     = '0;
    blank_cnt   = '0;
    first_blank = '0;
    ln          = 32'(line_q);
    ci          = 0;
    code        = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      if (ln < NU)            ci = ln*NU + k;
      else if (ln < 2*NU)     ci = k*NU + (ln - NU);
      else if (ln == 2*NU)    ci = k*(NU + 1);
      else                    ci = (k + 1)*(NU - 1);
      code = board_q[2*ci +: 2];
      if (code == AI_CODE) begin
        ai_cnt = ai_cnt + 4'd1;
      end else if (code == OPP_CODE) begin
        opp_cnt = opp_cnt + 4'd1;
      end else if (code == 2'b00) begin
        // Cells along every line are visited in ascending index order,
        // so the first blank seen is the lowest-index one.
        if (blank_cnt == 4'd0) first_blank = IDX_W'(ci);
        blank_cnt = blank_cnt + 4'd1;
      end
    end
  end

  assign fill_code = board_q[{cell_q, 1'b0} +: 2];

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    mode_d    = mode_q;
    pend_d    = pend_q;
    line_d    = line_q;
    cell_d    = cell_q;
    move_d    = move_q;
    no_move_d = no_move_q;
    unique case (state_q)
      IDLE: begin
        // Start is captured one cycle ahead of the scan; busy stays low in
        // that capture cycle and further starts are ignored during it.
        if (pend_q) begin
          pend_d  = 1'b0;
          line_d  = '0;
          cell_d  = '0;
          state_d = (mode_q != 2'd0) ? SCAN_WIN : FILL;
        end else if (bus.start) begin
          pend_d    = 1'b1;
          board_d   = bus.board_state;
          mode_d    = bus.mode;
          move_d    = '0;
          no_move_d = 1'b0;
        end
      end
      SCAN_WIN: begin
        if (ai_cnt == CNT_HIT && blank_cnt == 4'd1) begin
          move_d  = first_blank;
          state_d = DONE;
        end else if (line_q == LAST_LINE) begin
          line_d  = '0;
          state_d = (mode_q >= 2'd2) ? SCAN_BLOCK : FILL;
        end else begin
          line_d = line_q + 1'b1;
        end
      end
      SCAN_BLOCK: begin
        if (opp_cnt == CNT_HIT && blank_cnt == 4'd1) begin
          move_d  = first_blank;
          state_d = DONE;
        end else if (line_q == LAST_LINE) begin
          line_d  = '0;
          state_d = (mode_q == 2'd3) ? CENTER : FILL;
        end else begin
          line_d = line_q + 1'b1;
        end
      end
      CENTER: begin
        if (ODD_N && board_q[2*CENTRE_I +: 2] == 2'b00) begin
          move_d  = CENTRE;
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (fill_code == 2'b00) begin
          move_d  = cell_q;
          state_d = DONE;
        end else if (cell_q == LAST_CELL) begin
          move_d    = '0;
          no_move_d = 1'b1;
          state_d   = DONE;
        end else begin
          cell_d = cell_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      board_q   <= '0;
      mode_q    <= '0;
      pend_q    <= 1'b0;
      line_q    <= '0;
      cell_q    <= '0;
      move_q    <= '0;
      no_move_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      line_q    <= line_d;
      cell_q    <= cell_d;
      move_q    <= move_d;
      no_move_q <= no_move_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.move_idx = move_q;
  assign bus.no_move  = no_move_q;

endmodule

// File: tb/tb_line_scan_ai.sv
module tb_line_scan_ai;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  line_scan_ai_if #(.N(3)) bus3 ();
  line_scan_ai_if #(.N(4)) bus4 ();
  line_scan_ai_if #(.N(5)) bus5 ();

  line_scan_ai #(.N(3), .AI_IS_O(1'b1)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));
  line_scan_ai #(.N(4), .AI_IS_O(1'b1)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
  line_scan_ai #(.N(5), .AI_IS_O(1'b0)) u_dut5 (.clk(clk), .reset(reset), .bus(bus5));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int n, input logic st, input logic [1:0] md, input logic [127:0] b);
    case (n)
      3: begin bus3.start = st; bus3.mode = md; bus3.board_state = b[17:0]; end
      4: begin bus4.start = st; bus4.mode = md; bus4.board_state = b[31:0]; end
      default: begin bus5.start = st; bus5.mode = md; bus5.board_state = b[49:0]; end
    endcase
  endtask

  task automatic sample(input int n, output logic dn, output logic bs, output int mv, output logic nm);
    case (n)
      3: begin dn = bus3.done; bs = bus3.busy; mv = int'(bus3.move_idx); nm = bus3.no_move; end
      4: begin dn = bus4.done; bs = bus4.busy; mv = int'(bus4.move_idx); nm = bus4.no_move; end
      default: begin dn = bus5.done; bs = bus5.busy; mv = int'(bus5.move_idx); nm = bus5.no_move; end
    endcase
  endtask

  function automatic logic [127:0] put(input logic [127:0] b, input int i, input logic [1:0] v);
    logic [127:0] r;
    r = b;
    r[2*i +: 2] = v;
    return r;
  endfunction

  function automatic logic [127:0] rand_board(input int n);
    logic [127:0] b;
    bit full;
    int r;
    b = '0;
    full = ($urandom_range(0, 5) == 0);
    for (int i = 0; i < n*n; i++) begin
      r = full ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 9));
      if (r <= 3)      b[2*i +: 2] = 2'b00;
      else if (r <= 6) b[2*i +: 2] = 2'b01;
      else if (r <= 8) b[2*i +: 2] = 2'b10;
      else             b[2*i +: 2] = 2'b11;
    end
    return b;
  endfunction

  // Reference: walk the lines by (row, col) coordinates, priority
  // win > block > centre > fill, and count the cycles each phase takes.
  function automatic void model(input int n, input int aic, input logic [127:0] b,
                                input logic [1:0] md, output int mv, output int nm,
                                output int lat);
    int nl, scan, who, own, bl, fb, r, c, i, ctr;
    nl = 2*n + 2;
    scan = 0;
    mv = 0; nm = 0; lat = -1;
    for (int ph = 0; ph < 2; ph++) begin
      if (int'(md) >= ph + 1) begin
        who = (ph == 0) ? aic : 3 - aic;
        for (int l = 0; l < nl; l++) begin
          own = 0; bl = 0; fb = 999;
          for (int k = 0; k < n; k++) begin
            if (l < n)            begin r = l; c = k; end
            else if (l < 2*n)     begin r = k; c = l - n; end
            else if (l == 2*n)    begin r = k; c = k; end
            else                  begin r = k; c = n - 1 - k; end
            i = r*n + c;
            if (int'(b[2*i +: 2]) == who) own++;
            else if (b[2*i +: 2] == 2'b00) begin
              bl++;
              if (i < fb) fb = i;
            end
          end
          if (own == n - 1 && bl == 1) begin
            mv = fb; lat = 2 + scan + l;
            return;
          end
        end
        scan += nl;
      end
    end
    if (md == 2'd3) begin
      ctr = (n*n - 1) / 2;
      if ((n % 2) == 1 && b[2*ctr +: 2] == 2'b00) begin
        mv = ctr; lat = 2 + scan;
        return;
      end
      scan += 1;
    end
    for (int cc = 0; cc < n*n; cc++) begin
      if (b[2*cc +: 2] == 2'b00) begin
        mv = cc; lat = 2 + scan + cc;
        return;
      end
    end
    nm = 1; mv = 0; lat = 2 + scan + n*n - 1;
  endfunction

  // One request: start sampled at edge 0, outputs sampled on each falling
  // edge (cycle k = period after edge k). inj >= 0 pulses a stray start.
  task automatic run(input string tag, input int n, input logic [127:0] b,
                     input logic [1:0] md, input int inj);
    int aic, exp_mv, exp_nm, exp_lat, done_cyc, got_mv, got_nm, busy_bad, extra, mvs;
    logic dn, bs, nms;
    aic = (n == 5) ? 1 : 2;
    model(n, aic, b, md, exp_mv, exp_nm, exp_lat);
    done_cyc = -1; got_mv = -1; got_nm = -1; busy_bad = 0;
    @(negedge clk);
    drive(n, 1'b1, md, b);
    @(posedge clk);
    for (int cyc = 0; cyc <= exp_lat + 4; cyc++) begin
      @(negedge clk);
      sample(n, dn, bs, mvs, nms);
      if (bs !== (cyc >= 1 && cyc <= exp_lat)) busy_bad++;
      if (dn === 1'b1) begin
        done_cyc = cyc; got_mv = mvs; got_nm = int'(nms);
      end
      if (cyc == 0) drive(n, 1'b0, 2'($urandom_range(0, 3)), rand_board(n));
      if (inj >= 0 && cyc == inj) drive(n, 1'b1, 2'($urandom_range(0, 3)), rand_board(n));
      if (inj >= 0 && cyc == inj + 1) drive(n, 1'b0, md, b);
      if (dn === 1'b1) break;
    end
    drive(n, 1'b0, md, b);
    check({tag, ".done_cycle"}, done_cyc, exp_lat);
    check({tag, ".move_idx"}, got_mv, exp_mv);
    check({tag, ".no_move"}, got_nm, exp_nm);
    check({tag, ".busy"}, busy_bad, 0);
    if (inj >= 0) begin
      extra = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        sample(n, dn, bs, mvs, nms);
        if (dn === 1'b1 || bs === 1'b1) extra++;
      end
      check({tag, ".extra_activity"}, extra, 0);
    end
  endtask

  initial begin
    logic [127:0] b;
    logic dn, bs, nms;
    int mvs, cnt, n, inj;
    logic [1:0] md;
    drive(3, 1'b0, 2'd0, '0);
    drive(4, 1'b0, 2'd0, '0);
    drive(5, 1'b0, 2'd0, '0);
    #1;
    sample(3, dn, bs, mvs, nms);
    check("reset.busy", int'(bs), 0);
    check("reset.done", int'(dn), 0);
    check("reset.move_idx", mvs, 0);
    check("reset.no_move", int'(nms), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Empty board, full strategy: centre.
    run("empty_m3", 3, '0, 2'd3, -1);

    // Win on row 0 beats block at cell 5.
    b = '0;
    b = put(b, 0, 2'b10); b = put(b, 1, 2'b10);
    b = put(b, 3, 2'b01); b = put(b, 4, 2'b01);
    run("win_row0", 3, b, 2'd3, -1);

    // No win, no block, falls through to fill.
    b = '0;
    b = put(b, 0, 2'b01); b = put(b, 4, 2'b01); b = put(b, 8, 2'b10);
    run("fill_m2", 3, b, 2'd2, -1);

    // N=4 block on main diagonal.
    b = '0;
    b = put(b, 0, 2'b01); b = put(b, 5, 2'b01); b = put(b, 10, 2'b01);
    b = put(b, 1, 2'b10); b = put(b, 2, 2'b10);
    run("block_diag4", 4, b, 2'd3, -1);

    // Full board including a reserved code.
    b = '0;
    b = put(b, 0, 2'b01); b = put(b, 1, 2'b10); b = put(b, 2, 2'b01);
    b = put(b, 3, 2'b10); b = put(b, 4, 2'b01); b = put(b, 5, 2'b10);
    b = put(b, 6, 2'b10); b = put(b, 7, 2'b01); b = put(b, 8, 2'b11);
    run("full_m0", 3, b, 2'd0, -1);

    // Stray start while busy is ignored.
    run("stray_start", 3, '0, 2'd3, 3);

    // Reset mid-scan aborts without a done pulse.
    @(negedge clk);
    drive(3, 1'b1, 2'd3, '0);
    @(posedge clk);
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc == 0) drive(3, 1'b0, 2'd3, '0);
    end
    @(negedge clk);
    sample(3, dn, bs, mvs, nms);
    check("pre_reset.busy", int'(bs), 1);
    #2 reset = 1'b1;
    #1;
    sample(3, dn, bs, mvs, nms);
    check("mid_reset.busy", int'(bs), 0);
    check("mid_reset.done", int'(dn), 0);
    check("mid_reset.move_idx", mvs, 0);
    check("mid_reset.no_move", int'(nms), 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      sample(3, dn, bs, mvs, nms);
      if (dn === 1'b1 || bs === 1'b1) cnt++;
    end
    check("post_reset.activity", cnt, 0);

    // Randomized requests across all three configurations.
    for (int t = 0; t < 45; t++) begin
      n = 3 + int'($urandom_range(0, 2));
      md = 2'($urandom_range(0, 3));
      b = rand_board(n);
      inj = ($urandom_range(0, 7) == 0) ? 2 : -1;
      run($sformatf("rand%0d_n%0d", t, n), n, b, md, inj);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
